// File: rtl/seq_div4.sv
// ---------------------------------------------------------------------------
// seq_div4 -- 4-bit unsigned sequential restoring divider.
//
// One quotient bit is produced per clock, MSB first, so a division takes
// four CALC cycles followed by a single DONE cycle.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous reset, active-low
//   start        request to begin a division (sampled only in IDLE)
//   dividend     unsigned numerator, latched when start is accepted
//   divisor      unsigned denominator, latched when start is accepted
//   quotient     registered result, updated when a division finishes
//   remainder    registered result, updated when a division finishes
//   busy         high while the division is being computed
//   done         one-cycle pulse in the cycle spent in DONE
//   div_by_zero  last accepted divisor was zero (DBZ build only, else 0)
//
// Handshake: start is a level request. It is taken on a rising edge only
// while the block is IDLE, and the operands are captured on that same edge.
// Any start seen in CALC or DONE is ignored. A start held high is accepted
// again on the first edge back in IDLE.
//
// Build option
//   SEQ_DIV4_DBZ_EN  when defined, a zero divisor skips the iterations and
//                    finishes after one CALC cycle with div_by_zero set.
//                    When undefined, a zero divisor runs the normal loop
//                    and div_by_zero is tied to 0.
//
// The current FSM state is held in the signal 'state' for probing.
// ---------------------------------------------------------------------------
module seq_div4 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] dividend,
    input  logic [3:0] divisor,
    output logic [3:0] quotient,
    output logic [3:0] remainder,
    output logic       busy,
    output logic       done,
    output logic       div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] dd_work;   // dividend, shifted left as bits are consumed
    logic [3:0] dv_work;   // latched divisor
    logic [4:0] r_work;    // partial remainder
    logic [3:0] q_work;    // quotient bits gathered so far
    logic [1:0] cnt;       // iteration index, 3 marks the final iteration

    logic [4:0] r_shift;
    logic [4:0] trial;
    logic       q_bit;
    logic [4:0] r_next;
    logic [3:0] q_next;

    // One restoring step. r_work never exceeds four significant bits, so
    // the shifted value fits in five bits and trial[4] acts as the sign.
    always_comb begin
        r_shift = {r_work[3:0], dd_work[3]};
        trial   = r_shift - {1'b0, dv_work};
        q_bit   = ~trial[4];
        r_next  = q_bit ? trial : r_shift;
        q_next  = {q_work[2:0], q_bit};
    end

`ifdef SEQ_DIV4_DBZ_EN
    logic dbz_q;
    assign div_by_zero = dbz_q;
`else
    assign div_by_zero = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            dd_work   <= '0;
            dv_work   <= '0;
            r_work    <= '0;
            q_work    <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef SEQ_DIV4_DBZ_EN
            dbz_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        dd_work <= dividend;
                        dv_work <= divisor;
                        r_work  <= '0;
                        q_work  <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= CALC;
                    end
                end

                CALC: begin
`ifdef SEQ_DIV4_DBZ_EN
                    if (dv_work == 4'd0) begin
                        // Short-circuit: dd_work is untouched after one
                        // cycle in CALC, so it still holds the dividend.
                        quotient  <= 4'hF;
                        remainder <= dd_work;
                        dbz_q     <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        cnt       <= '0;
                        state     <= DONE;
                    end else begin
`endif
                        r_work  <= r_next;
                        q_work  <= q_next;
                        dd_work <= {dd_work[2:0], 1'b0};
                        cnt     <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            quotient  <= q_next;
                            remainder <= r_next[3:0];
`ifdef SEQ_DIV4_DBZ_EN
                            dbz_q     <= 1'b0;
`endif
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end
`ifdef SEQ_DIV4_DBZ_EN
                    end
`endif
                end

                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div4.sv
// ---------------------------------------------------------------------------
// tb_seq_div4 -- directed self-checking bench for seq_div4.
// Inputs are driven 1 time unit after each rising edge and outputs are
// sampled at the same point, away from the active edge.
// ---------------------------------------------------------------------------
module tb_seq_div4;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    int checks   = 0;
    int failures = 0;

    logic [3:0] last_q = 4'd0;
    logic [3:0] last_r = 4'd0;

`ifdef SEQ_DIV4_DBZ_EN
    localparam int  DBZ_LAT = 1;
    localparam logic DBZ_FLAG = 1'b1;
`else
    localparam int  DBZ_LAT = 4;
    localparam logic DBZ_FLAG = 1'b0;
`endif

    seq_div4 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Launch one division, track it to done and check result, latency,
    // result hold during CALC and result hold after done.
    task automatic run_div(input string tag, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] eq, input logic [3:0] er,
                           input logic edbz, input int elat);
        int n;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        step();                               // E0
        start    = 1'b0;
        dividend = 4'($urandom_range(0, 15)); // must not disturb latched operands
        divisor  = 4'($urandom_range(0, 15));
        chk({tag, "_busy_e0"}, {7'd0, busy}, 8'd1);
        chk({tag, "_hold_q"}, {4'd0, quotient}, {4'd0, last_q});
        n = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            n++;
            if (done) break;
        end
        chk({tag, "_done_seen"}, {7'd0, done}, 8'd1);
        chk({tag, "_latency"}, 8'(n), 8'(elat));
        chk({tag, "_quot"}, {4'd0, quotient}, {4'd0, eq});
        chk({tag, "_rem"}, {4'd0, remainder}, {4'd0, er});
        chk({tag, "_dbz"}, {7'd0, div_by_zero}, {7'd0, edbz});
        chk({tag, "_busy_done"}, {7'd0, busy}, 8'd0);
        step();
        chk({tag, "_done_pulse"}, {7'd0, done}, 8'd0);
        step();
        chk({tag, "_result_hold"}, {quotient, remainder}, {eq, er});
        last_q = eq;
        last_r = er;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 4'd0;
        divisor  = 4'd0;
        #3;
        chk("reset_async", {quotient, remainder}, 8'h00);
        chk("reset_flags", {5'd0, busy, done, div_by_zero}, 8'h00);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("idle_after_reset", {6'd0, busy, done}, 8'h00);

        run_div("d13_3", 4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 4);
        run_div("d15_1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 4);
        run_div("d2_5", 4'd2, 4'd5, 4'd0, 4'd2, 1'b0, 4);
        run_div("d0_7", 4'd0, 4'd7, 4'd0, 4'd0, 1'b0, 4);
        run_div("d9_0", 4'd9, 4'd0, 4'hF, 4'd9, DBZ_FLAG, DBZ_LAT);
        run_div("d13_3b", 4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 4);

        // Start ignored during CALC, then held high for back-to-back accept.
        start    = 1'b1;
        dividend = 4'd12;
        divisor  = 4'd4;
        step();                               // E0
        start    = 1'b0;
        step();                               // E1
        start    = 1'b1;
        dividend = 4'd1;
        divisor  = 4'd1;
        step();                               // E2
        chk("ign_busy_e2", {7'd0, busy}, 8'd1);
        step();                               // E3
        chk("ign_hold_q_e3", {4'd0, quotient}, {4'd0, last_q});
        step();                               // E4
        chk("ign_done_e4", {7'd0, done}, 8'd1);
        chk("ign_result", {quotient, remainder}, {4'd3, 4'd0});
        step();                               // E5
        chk("ign_idle_e5", {6'd0, busy, done}, 8'h00);
        step();                               // E6
        chk("held_accept_e6", {7'd0, busy}, 8'd1);
        start    = 1'b0;
        for (int i = 0; i < 4; i++) step();   // E7..E10
        chk("held_done_e10", {7'd0, done}, 8'd1);
        chk("held_result", {quotient, remainder}, {4'd1, 4'd0});
        step();
        chk("held_done_pulse", {7'd0, done}, 8'd0);
        last_q = 4'd1;
        last_r = 4'd0;

        // Reset mid-CALC.
        start    = 1'b1;
        dividend = 4'd14;
        divisor  = 4'd3;
        step();                               // E0
        start    = 1'b0;
        step();                               // E1
        step();                               // E2
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_results", {quotient, remainder}, 8'h00);
        chk("midrst_flags", {5'd0, busy, done, div_by_zero}, 8'h00);
        step();
        chk("midrst_held", {5'd0, busy, done, div_by_zero}, 8'h00);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("midrst_no_done", {6'd0, busy, done}, 8'h00);
        end
        last_q = 4'd0;
        last_r = 4'd0;
        run_div("d14_3", 4'd14, 4'd3, 4'd4, 4'd2, 1'b0, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the bench always ends on its own.
    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "time limit reached");
    end

endmodule
